fft_frame_loader: RTL and testbench

Parametrised ping-pong frame loader that sits in front of the FFT core. It accepts a stream of signed complex samples and packs them into NPTS-point frames. Each frame is presented to the core as a parallel bus under the enable/ret handshake: `fft_enable` is held high until the core returns `ret`, then dropped for one cycle before the next frame is issued. Two frame banks let the next frame load while the core is busy.

---
 rtl/fft_frame_loader_if.sv | 30 +++
 rtl/fft_frame_loader.sv | 149 ++++++++++++++
 tb/tb_fft_frame_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_loader_if.sv
// Stream-in / frame-out bus of the FFT frame loader.
// master : the loader (accepts samples, presents frames to the core)
// slave  : the sample source and FFT core side
//   s_valid/s_ready/s_re/s_im/s_last : sample stream into the loader
//   fft_re/fft_im                    : packed frame, point k at [k*DW +: DW]
//   fft_enable/fft_ret               : frame-valid / core-done handshake
interface fft_frame_loader_if #(
  parameter int unsigned DW   = 12,
  parameter int unsigned NPTS = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_re;
  logic [DW-1:0]        s_im;
  logic                 s_last;
  logic [NPTS*DW-1:0]   fft_re;
  logic [NPTS*DW-1:0]   fft_im;
  logic                 fft_enable;
  logic                 fft_ret;

  modport master (
    input  s_valid, s_re, s_im, s_last, fft_ret,
    output s_ready, fft_re, fft_im, fft_enable
  );

  modport slave (
    output s_valid, s_re, s_im, s_last, fft_ret,
    input  s_ready, fft_re, fft_im, fft_enable
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader in front of the FFT core. Packs a stream of complex
// samples into NPTS-point frames held in two banks, and issues each full
// bank to the core as a registered parallel bus under enable/ret.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   bus (master)  : sample stream in, frame bus + enable/ret handshake out
//   o_frame_cnt   : frames completed by the core (wraps)
//   o_err_len     : sticky frame-length error (short or over-long frame)
module fft_frame_loader #(
  parameter int unsigned DW   = 12,
  parameter int unsigned NPTS = 32,
  parameter int unsigned CW   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fft_frame_loader_if.master    bus,
  output logic [CW-1:0]         o_frame_cnt,
  output logic                  o_err_len
);

  localparam int unsigned AW = $clog2(NPTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NPTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

  logic [DW-1:0]      r_bank_re [2][NPTS];
  logic [DW-1:0]      r_bank_im [2][NPTS];
  logic [1:0]         r_full;
  logic               r_wr_sel;
  logic               r_rd_sel;
  logic [AW-1:0]      r_widx;
  state_t             r_state;
  logic               r_fft_enable;
  logic [NPTS*DW-1:0] r_fft_re;
  logic [NPTS*DW-1:0] r_fft_im;
  logic [CW-1:0]      r_frame_cnt;
  logic               r_err_len;

  logic w_accept;
  logic w_wr_done;
  logic w_rd_done;
  logic w_load;

  assign bus.s_ready    = !i_rst && !r_full[r_wr_sel];
  assign bus.fft_re     = r_fft_re;
  assign bus.fft_im     = r_fft_im;
  assign bus.fft_enable = r_fft_enable;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_err_len      = r_err_len;

  assign w_accept  = bus.s_valid && bus.s_ready;
  assign w_wr_done = w_accept && (r_widx == LAST_IDX);
  assign w_rd_done = (r_state == ST_RUN) && bus.fft_ret;
  // A bank is moved to the output bus whenever the FSM is about to enter RUN.
  assign w_load    = ((r_state == ST_IDLE) || (r_state == ST_GAP)) && r_full[r_rd_sel];

  // Sample storage; contents are only meaningful once the bank is marked full.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_bank_re[r_wr_sel][r_widx] <= bus.s_re;
      r_bank_im[r_wr_sel][r_widx] <= bus.s_im;
    end
  end

  // Write side: point index, bank pointer, length error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_widx    <= '0;
      r_wr_sel  <= 1'b0;
      r_err_len <= 1'b0;
    end else if (w_accept) begin
      if (r_widx == LAST_IDX) begin
        r_widx   <= '0;
        r_wr_sel <= ~r_wr_sel;
        if (!bus.s_last) r_err_len <= 1'b1;
      end else if (bus.s_last) begin
        // Short frame: drop it and restart the same bank.
        r_widx    <= '0;
        r_err_len <= 1'b1;
      end else begin
        r_widx <= r_widx + AW'(1);
      end
    end
  end

  // Bank full flags. Set and clear can never target the same bank on one
  // edge: the writer only fills an empty bank, the issuer only frees a full one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_done && (r_wr_sel == 1'(b)))
          r_full[b] <= 1'b1;
        else if (w_rd_done && (r_rd_sel == 1'(b)))
          r_full[b] <= 1'b0;
      end
    end
  end

  // Issue FSM with registered enable, frame bus and completion counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_rd_sel     <= 1'b0;
      r_fft_enable <= 1'b0;
      r_frame_cnt  <= '0;
      r_fft_re     <= '0;
      r_fft_im     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_sel]) begin
            r_state      <= ST_RUN;
            r_fft_enable <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.fft_ret) begin
            r_state      <= ST_GAP;
            r_fft_enable <= 1'b0;
            r_rd_sel     <= ~r_rd_sel;
            r_frame_cnt  <= r_frame_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (r_full[r_rd_sel]) begin
            r_state      <= ST_RUN;
            r_fft_enable <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_fft_enable <= 1'b0;
        end
      endcase

      if (w_load) begin
        for (int k = 0; k < int'(NPTS); k++) begin
          r_fft_re[k*DW +: DW] <= r_bank_re[r_rd_sel][k];
          r_fft_im[k*DW +: DW] <= r_bank_im[r_rd_sel][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader (DW=12, NPTS=32, CW=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fft_frame_loader;

  localparam int unsigned DW   = 12;
  localparam int unsigned NPTS = 32;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] frame_cnt;
  logic          err_len;

  int n_cmp = 0;
  int n_err = 0;

  fft_frame_loader_if #(.DW(DW), .NPTS(NPTS)) bus ();

  fft_frame_loader #(.DW(DW), .NPTS(NPTS), .CW(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_frame_cnt (frame_cnt),
    .o_err_len   (err_len)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Sample pattern: p=0 is the reference frame re=k-16, im=-3k.
  function automatic logic [DW-1:0] pre(int p, int k);
    if (p == 0) return DW'(k - 16);
    return DW'(p * 64 + k);
  endfunction

  function automatic logic [DW-1:0] pim(int p, int k);
    if (p == 0) return DW'(-3 * k);
    return DW'(-(p * 64) - k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample and hold it until it is accepted.
  task automatic push(input int p, input int k, input bit last);
    bit acc;
    bus.s_valid = 1'b1;
    bus.s_re    = pre(p, k);
    bus.s_im    = pim(p, k);
    bus.s_last  = last;
    for (int n = 0; n < 100; n++) begin
      acc = bus.s_ready;
      tick();
      if (acc) return;
    end
    chk("accept_timeout", 64'(0), 64'(1));
  endtask

  // Stream n samples of pattern p; s_last on the final one if with_last.
  task automatic send(input int p, input int n, input bit with_last);
    for (int k = 0; k < n; k++) push(p, k, with_last && (k == n - 1));
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int p);
    for (int k = 0; k < int'(NPTS); k++) begin
      chk({tag, "_re"}, 64'(bus.fft_re[k*DW +: DW]), 64'(pre(p, k)));
      chk({tag, "_im"}, 64'(bus.fft_im[k*DW +: DW]), 64'(pim(p, k)));
    end
  endtask

  task automatic pulse_ret();
    bus.fft_ret = 1'b1;
    tick();
    bus.fft_ret = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_re    = '0;
    bus.s_im    = '0;
    bus.s_last  = 1'b0;
    bus.fft_ret = 1'b0;

    // Reset held 3 cycles with valid high.
    tick(); tick(); tick();
    chk("rst_ready",  64'(bus.s_ready),    64'(0));
    chk("rst_enable", 64'(bus.fft_enable), 64'(0));
    chk("rst_cnt",    64'(frame_cnt),      64'(0));
    chk("rst_err",    64'(err_len),        64'(0));
    chk("rst_re_nz",  64'(|bus.fft_re),    64'(0));
    bus.s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.s_ready), 64'(1));

    // Single reference frame.
    send(0, 32, 1'b1);
    chk("single_en_e",  64'(bus.fft_enable), 64'(0));
    tick();
    chk("single_en_e1", 64'(bus.fft_enable), 64'(1));
    check_frame("single", 0);
    tick(); tick(); tick();
    chk("single_hold_en", 64'(bus.fft_enable), 64'(1));
    check_frame("single_hold", 0);
    pulse_ret();
    chk("single_gap_en", 64'(bus.fft_enable), 64'(0));
    chk("single_cnt",    64'(frame_cnt),      64'(1));
    tick();
    chk("single_idle_en", 64'(bus.fft_enable), 64'(0));
    tick();
    chk("single_idle_en2", 64'(bus.fft_enable), 64'(0));
    check_frame("single_idle_hold", 0);

    // Ping-pong: two frames fill both banks, third is back-pressured.
    send(1, 32, 1'b1);
    send(2, 32, 1'b1);
    chk("pp_run_en", 64'(bus.fft_enable), 64'(1));
    check_frame("pp_f1", 1);
    bus.s_valid = 1'b1;
    bus.s_re    = pre(3, 0);
    bus.s_im    = pim(3, 0);
    bus.s_last  = 1'b0;
    chk("pp_bp_ready0", 64'(bus.s_ready), 64'(0));
    tick();
    chk("pp_bp_ready1", 64'(bus.s_ready), 64'(0));
    tick();
    chk("pp_bp_ready2", 64'(bus.s_ready), 64'(0));
    pulse_ret();
    chk("pp_gap_en",    64'(bus.fft_enable), 64'(0));
    chk("pp_gap_ready", 64'(bus.s_ready),    64'(1));
    chk("pp_cnt2",      64'(frame_cnt),      64'(2));
    push(3, 0, 1'b0);
    chk("pp_f2_en", 64'(bus.fft_enable), 64'(1));
    check_frame("pp_f2", 2);
    for (int k = 1; k < 32; k++) push(3, k, k == 31);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("pp_full_ready", 64'(bus.s_ready), 64'(0));
    pulse_ret();
    chk("pp_cnt3",    64'(frame_cnt),      64'(3));
    chk("pp_gap2_en", 64'(bus.fft_enable), 64'(0));
    tick();
    chk("pp_f3_en", 64'(bus.fft_enable), 64'(1));
    check_frame("pp_f3", 3);
    pulse_ret();
    chk("pp_cnt4", 64'(frame_cnt), 64'(4));
    tick();
    chk("pp_idle_en", 64'(bus.fft_enable), 64'(0));

    // Short frame (s_last at index 9) is dropped, next frame is normal.
    send(4, 10, 1'b1);
    chk("short_err", 64'(err_len), 64'(1));
    tick(); tick();
    chk("short_no_en", 64'(bus.fft_enable), 64'(0));
    send(5, 32, 1'b1);
    tick();
    chk("after_short_en", 64'(bus.fft_enable), 64'(1));
    check_frame("after_short", 5);
    pulse_ret();
    chk("after_short_cnt", 64'(frame_cnt), 64'(5));
    tick();

    // Over-long: 32nd sample without s_last still issues.
    send(6, 32, 1'b0);
    tick();
    chk("long_en",  64'(bus.fft_enable), 64'(1));
    chk("long_err", 64'(err_len),        64'(1));
    check_frame("long", 6);
    pulse_ret();
    chk("long_cnt", 64'(frame_cnt), 64'(6));
    tick();

    // Ret held high across two queued frames.
    send(7, 32, 1'b1);
    send(8, 32, 1'b1);
    chk("abuse_run7_en", 64'(bus.fft_enable), 64'(1));
    check_frame("abuse_f7", 7);
    bus.fft_ret = 1'b1;
    tick();
    chk("abuse_gap1_en",  64'(bus.fft_enable), 64'(0));
    chk("abuse_gap1_cnt", 64'(frame_cnt),      64'(7));
    tick();
    chk("abuse_run8_en",  64'(bus.fft_enable), 64'(1));
    chk("abuse_run8_cnt", 64'(frame_cnt),      64'(7));
    check_frame("abuse_f8", 8);
    tick();
    chk("abuse_gap2_en",  64'(bus.fft_enable), 64'(0));
    chk("abuse_gap2_cnt", 64'(frame_cnt),      64'(8));
    tick();
    chk("abuse_idle_en",  64'(bus.fft_enable), 64'(0));
    tick();
    chk("abuse_idle_cnt", 64'(frame_cnt),      64'(8));
    bus.fft_ret = 1'b0;
    pulse_ret();
    chk("idle_ret_cnt", 64'(frame_cnt), 64'(8));

    // Reset mid-RUN with the other bank full.
    send(9, 32, 1'b1);
    send(10, 32, 1'b1);
    chk("pre_rst_en", 64'(bus.fft_enable), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_en",    64'(bus.fft_enable), 64'(0));
    chk("mid_rst_cnt",   64'(frame_cnt),      64'(0));
    chk("mid_rst_err",   64'(err_len),        64'(0));
    chk("mid_rst_re_nz", 64'(|bus.fft_re),    64'(0));
    chk("mid_rst_ready", 64'(bus.s_ready),    64'(1));
    tick(); tick(); tick();
    chk("mid_rst_no_stale", 64'(bus.fft_enable), 64'(0));
    send(11, 32, 1'b1);
    tick();
    chk("fresh_en", 64'(bus.fft_enable), 64'(1));
    check_frame("fresh", 11);
    pulse_ret();
    chk("fresh_cnt", 64'(frame_cnt), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
